// File: rtl/vc_arbiter_ctrl.sv
// vc_arbiter_ctrl: transmit-side scheduler draining two virtual-channel FIFOs
// (VC0, VC1) into two destination FIFOs (D0, D1). It pops at most one word per
// cycle using weighted priority: VC0 is favoured for up to 'weight' consecutive
// grants, and VC1 is never starved. Each popped word is steered to D0 or D1 by
// the routing bit DEST_BIT. Read-to-write latency is 1 cycle.
// Ports:
//   clk, reset (sync, active-low), init, cfg_vc0_weight  - clock, reset, configuration
//   vc*_empty/data/error, d*_full/almost_full/error      - FIFO status and data
//   vc*_rd, d*_wr, d_data                                - FIFO read and write strobes
//   state, idle, error_out                               - controller status
module vc_arbiter_ctrl #(
  parameter int DATA_WIDTH     = 6,
  parameter int DEST_BIT       = 4,
  parameter int WEIGHT_WIDTH   = 3,
  parameter int WEIGHT_DEFAULT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [WEIGHT_WIDTH-1:0] cfg_vc0_weight,
  input  logic                    vc0_empty,
  input  logic                    vc1_empty,
  input  logic [DATA_WIDTH-1:0]   vc0_data,
  input  logic [DATA_WIDTH-1:0]   vc1_data,
  input  logic                    vc0_error,
  input  logic                    vc1_error,
  input  logic                    d0_full,
  input  logic                    d0_almost_full,
  input  logic                    d1_full,
  input  logic                    d1_almost_full,
  input  logic                    d0_error,
  input  logic                    d1_error,
  output logic                    vc0_rd,
  output logic                    vc1_rd,
  output logic                    d0_wr,
  output logic                    d1_wr,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic [2:0]              state,
  output logic                    idle,
  output logic                    error_out
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                  st;
  logic [WEIGHT_WIDTH-1:0] weight;
  logic [WEIGHT_WIDTH-1:0] wcnt;
  logic [WEIGHT_WIDTH-1:0] weff;
  logic                    vld_q;
  logic                    src_q;
  logic                    any_err;
  logic                    can_pop;
  logic                    gnt0;
  logic                    gnt1;
  logic                    wr_ok;
  logic [DATA_WIDTH-1:0]   word;

  assign any_err = vc0_error | vc1_error | d0_error | d1_error;

  // A zero weight would starve VC0 entirely; treat it as 1.
  assign weff = (weight == '0) ? WEIGHT_WIDTH'(1) : weight;

  // The destination is only known after the read, so both destinations gate
  // the pop. An error input takes priority: no new pop into a dying pipeline.
  assign can_pop = (st == S_ACTIVE) & ~any_err &
                   ~d0_full & ~d0_almost_full & ~d1_full & ~d1_almost_full;

  assign gnt0 = can_pop & ~vc0_empty & ((wcnt < weff) | vc1_empty);
  assign gnt1 = can_pop & ~vc1_empty & ~gnt0;

  // The in-flight word is written only while still ACTIVE with no error;
  // entering ERROR (or an error arriving now) drops it.
  assign wr_ok = reset & vld_q & (st == S_ACTIVE) & ~any_err;
  assign word  = src_q ? vc1_data : vc0_data;

  assign vc0_rd    = reset & gnt0;
  assign vc1_rd    = reset & gnt1;
  assign d0_wr     = wr_ok & ~word[DEST_BIT];
  assign d1_wr     = wr_ok &  word[DEST_BIT];
  assign d_data    = wr_ok ? word : '0;
  assign state     = reset ? st : S_RESET;
  assign idle      = reset & (st == S_IDLE);
  assign error_out = reset & (st == S_ERROR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      st     <= S_RESET;
      weight <= WEIGHT_WIDTH'(WEIGHT_DEFAULT);
      wcnt   <= '0;
      vld_q  <= 1'b0;
      src_q  <= 1'b0;
    end else begin
      vld_q <= gnt0 | gnt1;
      if (gnt1) begin
        src_q <= 1'b1;
      end else if (gnt0) begin
        src_q <= 1'b0;
      end

      if (gnt1) begin
        wcnt <= '0;
      end else if (gnt0) begin
        wcnt <= (wcnt < weff) ? wcnt + WEIGHT_WIDTH'(1) : weff;
      end

      case (st)
        S_RESET: st <= S_INIT;
        S_INIT: begin
          weight <= cfg_vc0_weight;
          if (any_err)   st <= S_ERROR;
          else if (!init) st <= S_IDLE;
        end
        S_IDLE: begin
          if (any_err)                      st <= S_ERROR;
          else if (init)                    st <= S_INIT;
          else if (!vc0_empty || !vc1_empty) st <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (any_err)                                st <= S_ERROR;
          else if (vc0_empty && vc1_empty && !vld_q) st <= S_IDLE;
        end
        S_ERROR: st <= S_ERROR;
        default: st <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
module tb_vc_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [2:0] cfg_vc0_weight;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       vc0_error, vc1_error, d0_error, d1_error;
  logic       d0_full, d0_almost_full, d1_full, d1_almost_full;
  logic       vc0_rd, vc1_rd, d0_wr, d1_wr;
  logic [5:0] d_data;
  logic [2:0] state;
  logic       idle, error_out;

  vc_arbiter_ctrl dut (
    .clk(clk), .reset(reset), .init(init), .cfg_vc0_weight(cfg_vc0_weight),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .vc0_error(vc0_error), .vc1_error(vc1_error),
    .d0_full(d0_full), .d0_almost_full(d0_almost_full),
    .d1_full(d1_full), .d1_almost_full(d1_almost_full),
    .d0_error(d0_error), .d1_error(d1_error),
    .vc0_rd(vc0_rd), .vc1_rd(vc1_rd), .d0_wr(d0_wr), .d1_wr(d1_wr),
    .d_data(d_data), .state(state), .idle(idle), .error_out(error_out)
  );

  always #5 clk = ~clk;

  // Source FIFO contents; the read-data registers are loaded on a pop.
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  // Observed grants (0/1) and writes ({dest, data}).
  int         glog[$];
  logic [6:0] wlog[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic last_rd, r0, r1;

  // Reference model: controller mode, weight, run length of VC0 grants and
  // the word (if any) fetched last cycle.
  int         m_mode;   // 0 reset, 1 init, 2 idle, 3 active, 4 error
  int         m_weight;
  int         m_run;
  bit         m_pend;
  logic [5:0] m_word;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    int  limit;
    bit  err, bp, e0, e1, wr;
    logic [5:0] ed;
    if (!reset) begin
      chk("rst_vc0_rd", vc0_rd, 0); chk("rst_vc1_rd", vc1_rd, 0);
      chk("rst_d0_wr", d0_wr, 0);   chk("rst_d1_wr", d1_wr, 0);
      chk("rst_d_data", d_data, 0); chk("rst_state", state, 0);
      chk("rst_idle", idle, 0);     chk("rst_error_out", error_out, 0);
      m_mode = 0; m_weight = 3; m_run = 0; m_pend = 0;
      return;
    end
    err   = vc0_error | vc1_error | d0_error | d1_error;
    bp    = d0_full | d0_almost_full | d1_full | d1_almost_full;
    limit = (m_weight == 0) ? 1 : m_weight;
    e0 = (m_mode == 3) && !err && !bp && q0.size() > 0 &&
         (m_run < limit || q1.size() == 0);
    e1 = (m_mode == 3) && !err && !bp && !e0 && q1.size() > 0;
    wr = (m_mode == 3) && !err && m_pend;
    ed = wr ? m_word : 6'd0;
    chk("vc0_rd", vc0_rd, e0);
    chk("vc1_rd", vc1_rd, e1);
    chk("d0_wr", d0_wr, wr && !m_word[4]);
    chk("d1_wr", d1_wr, wr && m_word[4]);
    chk("d_data", d_data, ed);
    chk("state", state, m_mode);
    chk("idle", idle, m_mode == 2);
    chk("error_out", error_out, m_mode == 4);
    // advance to the next cycle
    case (m_mode)
      0: m_mode = 1;
      1: begin
        m_weight = cfg_vc0_weight;
        if (err) m_mode = 4; else if (!init) m_mode = 2;
      end
      2: if (err) m_mode = 4; else if (init) m_mode = 1;
         else if (q0.size() > 0 || q1.size() > 0) m_mode = 3;
      3: if (err) m_mode = 4;
         else if (q0.size() == 0 && q1.size() == 0 && !m_pend) m_mode = 2;
      default: m_mode = 4;
    endcase
    if (e0) begin m_word = q0[0]; m_run = (m_run + 1 > limit) ? limit : m_run + 1; end
    if (e1) begin m_word = q1[0]; m_run = 0; end
    m_pend = e0 || e1;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    r0 = vc0_rd; r1 = vc1_rd;
    last_rd = r0 | r1;
    if (r0) glog.push_back(0);
    if (r1) glog.push_back(1);
    if (d0_wr) wlog.push_back({1'b0, d_data});
    if (d1_wr) wlog.push_back({1'b1, d_data});
    @(posedge clk);
    #1;
    cyc++;
    if (r0 && q0.size() > 0) vc0_data = q0.pop_front();
    if (r1 && q1.size() > 0) vc1_data = q1.pop_front();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
  endtask

  task automatic push0(input logic [5:0] w);
    q0.push_back(w); vc0_empty = 1'b0;
  endtask

  task automatic push1(input logic [5:0] w);
    q1.push_back(w); vc1_empty = 1'b0;
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!last_rd && n < 30) begin step(); n++; end
    chk({name, "_timeout"}, last_rd, 1);
  endtask

  int exp_g[8] = '{0, 0, 1, 0, 0, 1, 0, 0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 0; init = 1; cfg_vc0_weight = 3'd2;
    vc0_empty = 1; vc1_empty = 1; vc0_data = 0; vc1_data = 0;
    vc0_error = 0; vc1_error = 0; d0_error = 0; d1_error = 0;
    d0_full = 0; d0_almost_full = 0; d1_full = 0; d1_almost_full = 0;
    last_rd = 0;
    #1;

    // Reset, then INIT with weight 2, then IDLE.
    step(); step();
    chk("lit_reset_state", state, 0);
    reset = 1;
    step();
    chk("lit_init_state", state, 1);
    step();
    init = 0;
    step();
    chk("lit_idle_state", state, 2);
    chk("lit_idle_flag", idle, 1);

    // Weighted order with weight 2: VC0 x6, VC1 x2.
    glog.delete();
    for (int i = 0; i < 6; i++) push0(6'($urandom_range(0, 63)));
    for (int i = 0; i < 2; i++) push1(6'($urandom_range(0, 63)));
    for (int n = 0; n < 40 && glog.size() < 8; n++) step();
    chk("lit_grant_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("lit_grant_order", glog[i], exp_g[i]);
    step(); step(); step();

    // Routing bit steers words.
    wlog.delete();
    push0(6'h00); push0(6'h10);
    for (int n = 0; n < 20 && wlog.size() < 2; n++) step();
    chk("lit_route_count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("lit_route_first", wlog[0], 7'h00);
      chk("lit_route_second", wlog[1], 7'h50);
    end

    // Almost-full on D1 blocks pops; release resumes next cycle.
    d1_almost_full = 1;
    push0(6'h05); push0(6'h15); push0(6'h07);
    glog.delete();
    for (int i = 0; i < 5; i++) step();
    chk("lit_af_blocked", glog.size(), 0);
    d1_almost_full = 0;
    step();
    chk("lit_af_resume", glog.size(), 1);
    for (int i = 0; i < 6; i++) step();

    // Randomised traffic, backpressure, weights and init requests.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 8) push0(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 4) == 0 && q1.size() < 8) push1(6'($urandom_range(0, 63)));
      d0_full        = ($urandom_range(0, 15) == 0);
      d0_almost_full = ($urandom_range(0, 9) == 0);
      d1_full        = ($urandom_range(0, 15) == 0);
      d1_almost_full = ($urandom_range(0, 9) == 0);
      init           = ($urandom_range(0, 39) == 0);
      cfg_vc0_weight = 3'($urandom_range(0, 7));
      step();
    end
    d0_full = 0; d0_almost_full = 0; d1_full = 0; d1_almost_full = 0; init = 0;
    for (int i = 0; i < 4; i++) step();

    // Error with a word in flight: dropped, sticky ERROR.
    push0(6'h11); push0(6'h02); push0(6'h13); push0(6'h04);
    last_rd = 0;
    wait_rd("err_wait");
    vc1_error = 1;
    wlog.delete();
    step();
    vc1_error = 0;
    step(); step(); step();
    chk("lit_err_state", state, 4);
    chk("lit_err_flag", error_out, 1);
    chk("lit_err_no_wr", wlog.size(), 0);

    // Reset right after a pop: in-flight word discarded.
    reset = 0; step();
    reset = 1; init = 1; step(); step();
    init = 0; step();
    push0(6'h12); push0(6'h03);
    last_rd = 0;
    wait_rd("rst_wait");
    reset = 0;
    wlog.delete();
    step();
    chk("lit_rst_state", state, 0);
    reset = 1;
    init = 1;
    step(); step();
    chk("lit_rst_no_wr", wlog.size(), 0);
    init = 0;
    for (int i = 0; i < 10; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
